// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// Universal shift register: hold, shift right, shift left, parallel load.
// A framing counter tracks consecutive same-direction shifts and pulses
// word_done when WIDTH of them have completed one word.
//
// Parameters:
//   WIDTH  register width in bits (2..32)
//   CW     shift-counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk           rising-edge clock
//   sync_reset_n  synchronous active-low reset, highest priority
//   en            clock enable (0 = hold all state, word_done cleared)
//   mode          00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sr_in         serial input entering at the MSB on a right shift
//   sl_in         serial input entering at the LSB on a left shift
//   d             parallel load data
//   q             registered register contents
//   ser_out_r     q[0], the bit that leaves on a right shift
//   ser_out_l     q[WIDTH-1], the bit that leaves on a left shift
//   shift_cnt     consecutive same-direction shifts in the current word
//   word_done     one-cycle pulse after the WIDTH-th consecutive shift
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             sync_reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_WORD = CW'(WIDTH);

  // Direction encoding for last_dir: 0 = right, 1 = left.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             word_done_r;
  logic             word_done_nxt_s;
  logic             last_dir_r;
  logic             last_dir_nxt_s;
  logic             shift_s;
  logic             dir_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Decode whether this cycle shifts and in which direction.
  always_comb begin
    shift_s = 1'b0;
    dir_s   = last_dir_r;
    if (en) begin
      case (mode_s)
        MODE_RIGHT: begin
          shift_s = 1'b1;
          dir_s   = DIR_RIGHT;
        end
        MODE_LEFT: begin
          shift_s = 1'b1;
          dir_s   = DIR_LEFT;
        end
        default: begin
          shift_s = 1'b0;
          dir_s   = last_dir_r;
        end
      endcase
    end else begin
      shift_s = 1'b0;
      dir_s   = last_dir_r;
    end
  end

  // Candidate count for a shift: a fresh word or a direction change
  // restarts at 1, discarding any partial count of the old direction.
  always_comb begin
    cnt_inc_s = CNT_ONE;
    if ((cnt_r == CNT_ZERO) || (dir_s != last_dir_r)) begin
      cnt_inc_s = CNT_ONE;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // Next-state for data register, counter, direction and word pulse.
  always_comb begin
    q_nxt_s         = q_r;
    cnt_nxt_s       = cnt_r;
    last_dir_nxt_s  = last_dir_r;
    word_done_nxt_s = 1'b0;

    if (en) begin
      case (mode_s)
        MODE_RIGHT: q_nxt_s = {sr_in, q_r[WIDTH-1:1]};
        MODE_LEFT:  q_nxt_s = {q_r[WIDTH-2:0], sl_in};
        MODE_LOAD: begin
          q_nxt_s   = d;
          cnt_nxt_s = CNT_ZERO;
        end
        default:    q_nxt_s = q_r;
      endcase
    end else begin
      q_nxt_s = q_r;
    end

    // Completing a word wraps the count to 0 in the same edge as the
    // pulse, so shift_cnt never presents WIDTH.
    if (shift_s) begin
      last_dir_nxt_s = dir_s;
      if (cnt_inc_s == CNT_WORD) begin
        cnt_nxt_s       = CNT_ZERO;
        word_done_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s       = cnt_inc_s;
        word_done_nxt_s = 1'b0;
      end
    end else begin
      last_dir_nxt_s = last_dir_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      q_r         <= '0;
      cnt_r       <= CNT_ZERO;
      word_done_r <= 1'b0;
      last_dir_r  <= DIR_RIGHT;
    end else begin
      q_r         <= q_nxt_s;
      cnt_r       <= cnt_nxt_s;
      word_done_r <= word_done_nxt_s;
      last_dir_r  <= last_dir_nxt_s;
    end
  end

  assign q         = q_r;
  assign shift_cnt = cnt_r;
  assign word_done = word_done_r;
  // Serial outputs are taps of the registered q, not extra flops.
  assign ser_out_r = q_r[0];
  assign ser_out_l = q_r[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parameterised synchronous universal shift register with hold, shift-right, shift-left and parallel-load modes. It adds a framing counter that flags each completed word of WIDTH consecutive same-direction shifts. It is the storage/serialisation stage built from the team's synchronous-reset D flip-flop cells. It drives downstream flip-flop banks and serial links directly from registered outputs.

## Interface
Parameters:
- WIDTH, default 4: register width in bits; legal range 2..32.
- CW, default $clog2(WIDTH+1): shift-counter width (derived; not overridden).

Ports (clock and reset first):
- clk  input  1  rising-edge clock; the only clock.
- sync_reset_n  input  1  synchronous, active-low reset, sampled on rising clk; has priority over every other input.
- en  input  1  clock enable; 0 = hold everything, word_done forced 0.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_in  input  1  serial input for shift right (enters at MSB).
- sl_in  input  1  serial input for shift left (enters at LSB).
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- ser_out_r  output  1  equals q[0] (bit leaving on shift right).
- ser_out_l  output  1  equals q[WIDTH-1] (bit leaving on shift left).
- shift_cnt  output  CW  consecutive same-direction shifts in the current word, 0..WIDTH-1.
- word_done  output  1  one-cycle pulse: WIDTH-th consecutive same-direction shift just completed.

## Operation
- Reset (sync_reset_n=0 at an edge): q=0, shift_cnt=0, word_done=0, last_dir=0 (right). Overrides en and mode.
- en=0: q, shift_cnt and last_dir hold; word_done<=0.
- mode=00: same as en=0.
- mode=11: q<=d; shift_cnt<=0; word_done<=0; last_dir unchanged.
- mode=01 (right): q<={sr_in, q[WIDTH-1:1]}; dir=0.
- mode=10 (left): q<={q[WIDTH-2:0], sl_in}; dir=1.
- Counter on any shift:
  - next = 1 if (shift_cnt==0 or dir!=last_dir), else shift_cnt+1.
  - If next==WIDTH: shift_cnt<=0 and word_done<=1; otherwise shift_cnt<=next and word_done<=0.
  - last_dir<=dir.
- Direction change mid-word discards the partial count; the new direction counts from 1, with no word_done for the abandoned word.
- shift_cnt never shows WIDTH; the wrap to 0 coincides with the word_done pulse.
- ser_out_r and ser_out_l are plain wires from q; they are not separately registered.

## Timing
- All state is updated on the rising clk edge. Latency from input to q, shift_cnt or word_done is 1 cycle.
- word_done is high for exactly the cycle after the edge completing the word. Back-to-back words give a pulse every WIDTH cycles.
- Reset asserted mid-word clears the count, and no word_done is issued. The first shift after reset counts as 1.
- A load on the cycle after word_done is legal; the pulse is not extended.
- No combinational path from inputs to outputs.

## Test plan
- Reset: drive q to 4'hA, then sync_reset_n=0 for 1 edge with en=1, mode=11, d=4'hF -> q=0, shift_cnt=0, word_done=0.
- Load and hold: load d=4'h9, then mode=00 for 3 cycles, then en=0 with mode=01 for 2 cycles -> q stays 4'h9, shift_cnt=0, word_done=0 throughout.
- Shift right word: from q=0, 4 shifts right with sr_in=1,0,1,1 -> q=8,4,A,D. shift_cnt=1,2,3,0. word_done=1 only after the 4th edge. ser_out_r follows q[0].
- Shift left word: from load 4'h1, 4 shifts left with sl_in=0 -> q=2,4,8,0. ser_out_l=0,0,1,0. word_done pulse after the 4th edge.
- Direction change mid-word: 2 shifts right then 1 left -> shift_cnt=1,2,1 with no pulse. 3 more left shifts -> word_done after the 4th left shift.
- Continuous and interrupted words:
  - 8 consecutive right shifts -> word_done after edges 4 and 8.
  - Repeat with a load at edge 6 -> one pulse only (edge 4); shift_cnt=0 after the load.
